// File: rtl/clk_bundle_gen_pkg.sv
// Shared constants for the divided-clock bundle generator: default widths and FSM state encodings.
package clk_bundle_pkg;

   localparam int DEF_NUM_CLKS = 4;
   localparam int DEF_DIV_W    = 8;
   localparam int DEF_CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Plain-vector copies of the state encodings, so the state register can stay a logic vector.
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_DRAIN = DRAIN;

endpackage

// File: rtl/clk_bundle_gen_if.sv
// Lane configuration channel (valid/ready) between a config master and the bundle generator.
interface clk_bundle_gen_if
   import clk_bundle_pkg::*;
#(
   parameter int NUM_CLKS = DEF_NUM_CLKS,
   parameter int DIV_W    = DEF_DIV_W
);
   localparam int LANE_W = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;

   logic              i_cfg_valid;
   logic              o_cfg_ready;
   logic [LANE_W-1:0] i_cfg_lane;
   logic [DIV_W-1:0]  i_cfg_div;

   modport master (
      output i_cfg_valid,
      output i_cfg_lane,
      output i_cfg_div,
      input  o_cfg_ready
   );

   modport slave (
      input  i_cfg_valid,
      input  i_cfg_lane,
      input  i_cfg_div,
      output o_cfg_ready
   );

endinterface

// File: rtl/clk_lane_div.sv
// One divided-clock lane: half-period down-counter, registered toggle output and first-high pulse.
module clk_lane_div #(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_run,
   input  logic             i_drain,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_clk,
   output logic             o_edge,
   output logic             o_rise
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             edge_q, edge_d;
   logic             active;
   logic             expire;

   // While draining, only a lane that is still high keeps counting so it can fall on schedule.
   assign active = i_run || (i_drain && clk_q);
   assign expire = (cnt_q == '0);
   assign o_rise = i_run && expire && !clk_q;

   always_comb begin
      cnt_d  = cnt_q;
      clk_d  = clk_q;
      edge_d = 1'b0;
      if (i_load) begin
         cnt_d = i_div;
         clk_d = 1'b0;
      end else if (active) begin
         if (expire) begin
            clk_d  = !clk_q;
            cnt_d  = i_div;
            edge_d = o_rise;
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= '0;
         clk_q  <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         clk_q  <= clk_d;
         edge_q <= edge_d;
      end
   end

   assign o_clk  = clk_q;
   assign o_edge = edge_q;

endmodule

// File: rtl/clk_bundle_gen.sv
// Phase-aligned divided-clock bundle: run/drain FSM, per-lane divide shadows and top-lane edge counter.
module clk_bundle_gen
   import clk_bundle_pkg::*;
#(
   parameter int NUM_CLKS = DEF_NUM_CLKS,
   parameter int DIV_W    = DEF_DIV_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   clk_bundle_gen_if.slave     cfg,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic [CNT_W-1:0]    i_edge_limit,
   output logic [NUM_CLKS-1:0] o_clks,
   output logic [NUM_CLKS-1:0] o_edges,
   output logic [CNT_W-1:0]    o_edge_cnt,
   output logic                o_running,
   output logic                o_done
);

   logic [1:0]          state_q, state_d;
   logic [DIV_W-1:0]    div_q [NUM_CLKS];
   logic [DIV_W-1:0]    divLoad [NUM_CLKS];
   logic [CNT_W-1:0]    edgeCnt_q, edgeCnt_d;
   logic [CNT_W-1:0]    limit_q;
   logic                done_q;
   logic                cfgFire;
   logic                startFire;
   logic                runEn;
   logic                drainEn;
   logic [NUM_CLKS-1:0] laneRise;
   logic                unusedRise;

   assign cfg.o_cfg_ready = (state_q == ST_IDLE);
   assign cfgFire         = cfg.i_cfg_valid && cfg.o_cfg_ready;
   assign startFire       = (state_q == ST_IDLE) && i_start;
   assign runEn           = (state_q == ST_RUN);
   assign drainEn         = (state_q == ST_DRAIN);

   // A config write landing on the start edge is forwarded so that lane starts with the new value.
   always_comb begin
      for (int l = 0; l < NUM_CLKS; l++) begin
         divLoad[l] = (cfgFire && (int'(cfg.i_cfg_lane) == l)) ? cfg.i_cfg_div : div_q[l];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int l = 0; l < NUM_CLKS; l++) begin
            div_q[l] <= '0;
         end
      end else if (cfgFire) begin
         for (int l = 0; l < NUM_CLKS; l++) begin
            if (int'(cfg.i_cfg_lane) == l) begin
               div_q[l] <= cfg.i_cfg_div;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      edgeCnt_d = edgeCnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d   = ST_RUN;
               edgeCnt_d = '0;
            end
         end
         ST_RUN: begin
            if (laneRise[NUM_CLKS-1]) begin
               if (edgeCnt_q != '1) begin
                  edgeCnt_d = edgeCnt_q + CNT_W'(1);
               end
               if ((limit_q != '0) && (edgeCnt_d == limit_q)) begin
                  state_d = ST_DRAIN;
               end
            end
            if (i_stop) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (o_clks == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         edgeCnt_q <= '0;
         limit_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         edgeCnt_q <= edgeCnt_d;
         if (startFire) begin
            limit_q <= i_edge_limit;
         end
         done_q    <= drainEn && (o_clks == '0);
      end
   end

   for (genvar l = 0; l < NUM_CLKS; l++) begin : gLane
      clk_lane_div #(
         .DIV_W (DIV_W)
      ) uLane (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_load  (startFire),
         .i_run   (runEn),
         .i_drain (drainEn),
         .i_div   (divLoad[l]),
         .o_clk   (o_clks[l]),
         .o_edge  (o_edges[l]),
         .o_rise  (laneRise[l])
      );
   end

   // Only the top lane's rise feeds the edge counter; the other lanes' rise strobes are spare.
   assign unusedRise = ^laneRise;

   assign o_edge_cnt = edgeCnt_q;
   assign o_running  = (state_q != ST_IDLE);
   assign o_done     = done_q;

endmodule

// File: tb/tb_clk_bundle_gen.sv
// Directed bench for clk_bundle_gen: hand-computed lane waveforms, edge counts, drain and reset behaviour.
module tb_clk_bundle_gen;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic        i_stop;
   logic [15:0] i_edge_limit;
   logic [3:0]  o_clks;
   logic [3:0]  o_edges;
   logic [15:0] o_edge_cnt;
   logic        o_running;
   logic        o_done;

   int checkCount = 0;
   int failCount  = 0;

   clk_bundle_gen_if #(.NUM_CLKS(4), .DIV_W(8)) cfgIf ();

   clk_bundle_gen #(
      .NUM_CLKS (4),
      .DIV_W    (8),
      .CNT_W    (16)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .cfg          (cfgIf),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .i_edge_limit (i_edge_limit),
      .o_clks       (o_clks),
      .o_edges      (o_edges),
      .o_edge_cnt   (o_edge_cnt),
      .o_running    (o_running),
      .o_done       (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance n active edges; inputs set afterwards are sampled on the following edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cfgWrite(input logic [1:0] lane, input logic [7:0] div);
      cfgIf.i_cfg_valid = 1'b1;
      cfgIf.i_cfg_lane  = lane;
      cfgIf.i_cfg_div   = div;
      tick(1);
      cfgIf.i_cfg_valid = 1'b0;
   endtask

   // Pulse start for one edge with the given limit (edge E0 of a run).
   task automatic applyStimulus(input logic [15:0] limit);
      i_edge_limit = limit;
      i_start      = 1'b1;
      tick(1);
      i_start      = 1'b0;
   endtask

   task automatic pulseStop();
      i_stop = 1'b1;
      tick(1);
      i_stop = 1'b0;
   endtask

   initial begin
      i_rst_n           = 1'b0;
      i_start           = 1'b0;
      i_stop            = 1'b0;
      i_edge_limit      = '0;
      cfgIf.i_cfg_valid = 1'b0;
      cfgIf.i_cfg_lane  = '0;
      cfgIf.i_cfg_div   = '0;
      tick(3);
      i_rst_n = 1'b1;
      tick(1);

      checkOutput("rst_clks",    32'(o_clks), 32'h0);
      checkOutput("rst_edges",   32'(o_edges), 32'h0);
      checkOutput("rst_cnt",     32'(o_edge_cnt), 32'h0);
      checkOutput("rst_running", 32'(o_running), 32'h0);
      checkOutput("rst_done",    32'(o_done), 32'h0);
      checkOutput("rst_ready",   32'(cfgIf.o_cfg_ready), 32'h1);

      // Default divs of 0, limit 3: every lane toggles each cycle.
      applyStimulus(16'd3);
      checkOutput("t1_e0_running", 32'(o_running), 32'h1);
      checkOutput("t1_e0_ready",   32'(cfgIf.o_cfg_ready), 32'h0);
      checkOutput("t1_e0_clks",    32'(o_clks), 32'h0);
      tick(1);
      checkOutput("t1_e1_clks",  32'(o_clks), 32'hF);
      checkOutput("t1_e1_edges", 32'(o_edges), 32'hF);
      checkOutput("t1_e1_cnt",   32'(o_edge_cnt), 32'h1);
      tick(1);
      checkOutput("t1_e2_clks",  32'(o_clks), 32'h0);
      checkOutput("t1_e2_edges", 32'(o_edges), 32'h0);
      tick(1);
      checkOutput("t1_e3_cnt", 32'(o_edge_cnt), 32'h2);
      tick(2);
      checkOutput("t1_e5_clks",    32'(o_clks), 32'hF);
      checkOutput("t1_e5_cnt",     32'(o_edge_cnt), 32'h3);
      checkOutput("t1_e5_running", 32'(o_running), 32'h1);
      tick(1);
      checkOutput("t1_e6_clks", 32'(o_clks), 32'h0);
      checkOutput("t1_e6_done", 32'(o_done), 32'h0);
      tick(1);
      checkOutput("t1_e7_done",    32'(o_done), 32'h1);
      checkOutput("t1_e7_running", 32'(o_running), 32'h0);
      checkOutput("t1_e7_ready",   32'(cfgIf.o_cfg_ready), 32'h1);
      tick(1);
      checkOutput("t1_e8_done", 32'(o_done), 32'h0);
      checkOutput("t1_e8_cnt",  32'(o_edge_cnt), 32'h3);

      // Divs {0,1,2,3}, limit 2.
      cfgWrite(2'd0, 8'd0);
      cfgWrite(2'd1, 8'd1);
      cfgWrite(2'd2, 8'd2);
      cfgWrite(2'd3, 8'd3);
      applyStimulus(16'd2);
      tick(1);
      checkOutput("t2_e1_clks",  32'(o_clks), 32'h1);
      checkOutput("t2_e1_edges", 32'(o_edges), 32'h1);
      tick(1);
      checkOutput("t2_e2_clks",  32'(o_clks), 32'h2);
      checkOutput("t2_e2_edges", 32'(o_edges), 32'h2);
      tick(1);
      checkOutput("t2_e3_clks",  32'(o_clks), 32'h7);
      checkOutput("t2_e3_edges", 32'(o_edges), 32'h5);
      tick(1);
      checkOutput("t2_e4_clks",  32'(o_clks), 32'hC);
      checkOutput("t2_e4_edges", 32'(o_edges), 32'h8);
      checkOutput("t2_e4_cnt",   32'(o_edge_cnt), 32'h1);
      tick(8);
      checkOutput("t2_e12_clks",    32'(o_clks), 32'h8);
      checkOutput("t2_e12_cnt",     32'(o_edge_cnt), 32'h2);
      checkOutput("t2_e12_running", 32'(o_running), 32'h1);
      tick(3);
      checkOutput("t2_e15_clks",  32'(o_clks), 32'h8);
      checkOutput("t2_e15_edges", 32'(o_edges), 32'h0);
      tick(1);
      checkOutput("t2_e16_clks", 32'(o_clks), 32'h0);
      checkOutput("t2_e16_done", 32'(o_done), 32'h0);
      tick(1);
      checkOutput("t2_e17_done", 32'(o_done), 32'h1);

      // All divs 3, unlimited, stop while lanes are high.
      for (int l = 0; l < 4; l++) cfgWrite(2'(l), 8'd3);
      applyStimulus(16'd0);
      tick(4);
      checkOutput("t3_e4_clks", 32'(o_clks), 32'hF);
      checkOutput("t3_e4_cnt",  32'(o_edge_cnt), 32'h1);
      pulseStop();
      checkOutput("t3_e5_clks",    32'(o_clks), 32'hF);
      checkOutput("t3_e5_running", 32'(o_running), 32'h1);
      tick(2);
      checkOutput("t3_e7_clks", 32'(o_clks), 32'hF);
      tick(1);
      checkOutput("t3_e8_clks", 32'(o_clks), 32'h0);
      checkOutput("t3_e8_done", 32'(o_done), 32'h0);
      tick(1);
      checkOutput("t3_e9_done", 32'(o_done), 32'h1);
      checkOutput("t3_e9_cnt",  32'(o_edge_cnt), 32'h1);

      // Config write of lane 2 (div 5) on the start edge; a write during the run is ignored.
      cfgIf.i_cfg_valid = 1'b1;
      cfgIf.i_cfg_lane  = 2'd2;
      cfgIf.i_cfg_div   = 8'd5;
      applyStimulus(16'd0);
      cfgIf.i_cfg_div   = 8'd0;
      checkOutput("t4_e0_ready", 32'(cfgIf.o_cfg_ready), 32'h0);
      tick(1);
      cfgIf.i_cfg_valid = 1'b0;
      tick(3);
      checkOutput("t4_e4_clks",  32'(o_clks), 32'hB);
      checkOutput("t4_e4_edges", 32'(o_edges), 32'hB);
      tick(2);
      checkOutput("t4_e6_clks",  32'(o_clks), 32'hF);
      checkOutput("t4_e6_edges", 32'(o_edges), 32'h4);
      pulseStop();
      tick(1);
      checkOutput("t4_e8_clks", 32'(o_clks), 32'h4);
      tick(4);
      checkOutput("t4_e12_clks", 32'(o_clks), 32'h0);
      tick(1);
      checkOutput("t4_e13_done", 32'(o_done), 32'h1);

      // Lane 2 must still be at div 5, then an asynchronous reset mid-run.
      applyStimulus(16'd0);
      tick(1);
      checkOutput("t5_e1_clks", 32'(o_clks), 32'h0);
      tick(5);
      checkOutput("t5_e6_clks", 32'(o_clks), 32'hF);
      checkOutput("t5_e6_cnt",  32'(o_edge_cnt), 32'h1);
      i_rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_clks",    32'(o_clks), 32'h0);
      checkOutput("t5_rst_running", 32'(o_running), 32'h0);
      checkOutput("t5_rst_cnt",     32'(o_edge_cnt), 32'h0);
      checkOutput("t5_rst_ready",   32'(cfgIf.o_cfg_ready), 32'h1);
      tick(2);
      checkOutput("t5_rst_done", 32'(o_done), 32'h0);
      i_rst_n = 1'b1;
      tick(1);
      applyStimulus(16'd1);
      tick(1);
      checkOutput("t5_e1_clks_after", 32'(o_clks), 32'hF);
      checkOutput("t5_e1_cnt_after",  32'(o_edge_cnt), 32'h1);
      tick(1);
      checkOutput("t5_e2_clks_after", 32'(o_clks), 32'h0);
      tick(1);
      checkOutput("t5_e3_done", 32'(o_done), 32'h1);

      // Stop while every lane is low: one DRAIN cycle then done.
      for (int l = 0; l < 4; l++) cfgWrite(2'(l), 8'd1);
      applyStimulus(16'd0);
      pulseStop();
      checkOutput("t6_e1_running", 32'(o_running), 32'h1);
      checkOutput("t6_e1_clks",    32'(o_clks), 32'h0);
      checkOutput("t6_e1_done",    32'(o_done), 32'h0);
      tick(1);
      checkOutput("t6_e2_done",  32'(o_done), 32'h1);
      checkOutput("t6_e2_ready", 32'(cfgIf.o_cfg_ready), 32'h1);
      tick(1);
      checkOutput("t6_e3_done", 32'(o_done), 32'h0);
      checkOutput("t6_e3_cnt",  32'(o_edge_cnt), 32'h0);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
